ifetch_unit: RTL and testbench

- Instruction fetch front end. Sits directly upstream of the IF/ID pipeline register of the pipelined MIPS core.
- Issues word fetches to a variable-latency instruction memory through a req/ack handshake and buffers returned instructions in a small prefetch FIFO.
- Presents {PC+4, instruction} pairs to the decode stage with valid/ready flow control.
- Supports branch redirect with full flush, including discard of any in-flight fetch.

---
 rtl/ifetch_unit_pkg.sv | 18 +
 rtl/ifetch_unit_fetch_fifo.sv | 82 ++++++++
 rtl/ifetch_unit.sv | 141 ++++++++++++++
 tb/tb_ifetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg
// Shared definitions for the instruction fetch front end: default data path
// widths, the encoding used for an empty decode slot, and the request FSM
// state encoding used by ifetch_unit.
package ifetch_unit_pkg;

  localparam int          ADDR_W_DEF = 32;
  localparam int          INST_W_DEF = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FULL = 2'd2,
    ST_DROP = 2'd3
  } fetchState_e;

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// fetch_fifo
// Synchronous DEPTH-entry FIFO holding prefetched {PC+4, instruction} pairs.
// Ports:
//   clk, resetn  clock and asynchronous active-low reset
//   push_i       write data_i at the tail (ignored when full unless popping)
//   pop_i        drop the head entry (ignored when empty)
//   flush_i      empty the FIFO; wins over push and pop
//   data_i       entry to write
//   valid_o      FIFO holds at least one entry
//   count_o      number of entries held, 0..DEPTH
//   head_o       oldest entry (contents undefined when empty)
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + INST_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PTR_W-1:0] wrPtrQ, wrPtrD;
  logic [PTR_W-1:0] rdPtrQ, rdPtrD;
  logic [CNT_W-1:0] countQ, countD;
  logic             doPush;
  logic             doPop;

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign doPop  = pop_i & (countQ != '0);
  assign doPush = push_i & ((countQ != CNT_W'(DEPTH)) | doPop);

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap
  // naturally.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (flush_i) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (doPush) wrPtrD = wrPtrQ + PTR_W'(1);
      if (doPop)  rdPtrD = rdPtrQ + PTR_W'(1);
      if (doPush && !doPop)      countD = countQ + CNT_W'(1);
      else if (doPop && !doPush) countD = countQ - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Storage needs no reset: entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) memQ[wrPtrQ] <= data_i;
  end

  assign valid_o = (countQ != '0);
  assign count_o = countQ;
  assign head_o  = memQ[rdPtrQ];

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction fetch front end feeding the IF/ID register. Keeps one fetch
// outstanding to a variable-latency memory, buffers returned words in a
// prefetch FIFO and hands {PC+4, instruction} to decode. A branch redirect
// flushes everything, including the data of a fetch already in flight.
// Ports:
//   clk, resetn               clock and asynchronous active-low reset
//   iRedirect, iRedirectPC    taken branch and its target (word aligned here)
//   oImemReq, oImemAddr       fetch request, held until iImemAck
//   iImemAck, iImemData       memory response
//   oValid, oInst, oPCPlus4   FIFO head towards decode (zero when empty)
//   iReady                    decode takes the head this cycle
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iRedirectPC,
  output logic              oImemReq,
  output logic [ADDR_W-1:0] oImemAddr,
  input  logic              iImemAck,
  input  logic [INST_W-1:0] iImemData,
  output logic              oValid,
  output logic [INST_W-1:0] oInst,
  output logic [ADDR_W-1:0] oPCPlus4,
  input  logic              iReady
);

  localparam int               CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  fetchState_e              stateQ, stateD;
  logic [ADDR_W-1:0]        pcQ, pcD;
  logic [ADDR_W-1:0]        dropAddrQ, dropAddrD;
  logic [ADDR_W-1:0]        redirectPc;
  logic [ADDR_W-1:0]        pcPlus4;
  logic                     push;
  logic                     popFire;
  logic                     fifoValid;
  logic [CNT_W-1:0]         fifoCount;
  logic [CNT_W-1:0]         countAfterPush;
  logic [ADDR_W+INST_W-1:0] headEntry;

  assign redirectPc = iRedirectPC & ~ADDR_W'(3);
  assign pcPlus4    = pcQ + ADDR_W'(4);

  // Redirect beats both push and pop: the flushed FIFO must not gain or lose
  // entries in the same cycle.
  assign push           = (stateQ == ST_REQ) & iImemAck & ~iRedirect;
  assign popFire        = fifoValid & iReady & ~iRedirect;
  assign countAfterPush = popFire ? fifoCount : fifoCount + CNT_W'(1);

  fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (popFire),
    .flush_i (iRedirect),
    .data_i  ({pcPlus4, iImemData}),
    .valid_o (fifoValid),
    .count_o (fifoCount),
    .head_o  (headEntry)
  );

  // State, fetch PC and the stale address shown while a dropped fetch drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stateQ    <= ST_IDLE;
      pcQ       <= RESET_PC;
      dropAddrQ <= RESET_PC;
    end else begin
      stateQ    <= stateD;
      pcQ       <= pcD;
      dropAddrQ <= dropAddrD;
    end
  end

  // Next state and fetch PC. A redirect always retargets the PC; if a fetch
  // is still outstanding it is drained in DROP with its original address
  // held on the bus, and its data is thrown away.
  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    dropAddrD = dropAddrQ;

    if (iRedirect) begin
      pcD = redirectPc;
    end else if ((stateQ == ST_REQ) && iImemAck) begin
      pcD = pcPlus4;
    end

    case (stateQ)
      ST_IDLE: stateD = ST_REQ;
      ST_REQ: begin
        if (iRedirect) begin
          if (!iImemAck) begin
            stateD    = ST_DROP;
            dropAddrD = pcQ;
          end
        end else if (iImemAck && (countAfterPush == DEPTH_CNT)) begin
          stateD = ST_FULL;
        end
      end
      ST_FULL: begin
        if (iRedirect || popFire || (fifoCount != DEPTH_CNT)) stateD = ST_REQ;
      end
      ST_DROP: begin
        if (iImemAck) stateD = ST_REQ;
      end
      default: stateD = ST_IDLE;
    endcase
  end

  // Memory-side outputs decoded from the current state.
  always_comb begin
    oImemReq  = 1'b0;
    oImemAddr = pcQ;
    case (stateQ)
      ST_REQ:  oImemReq = 1'b1;
      ST_DROP: begin
        oImemReq  = 1'b1;
        oImemAddr = dropAddrQ;
      end
      default: ;
    endcase
  end

  assign oValid   = fifoValid;
  assign oPCPlus4 = fifoValid ? headEntry[ADDR_W+INST_W-1:INST_W] : '0;
  assign oInst    = fifoValid ? headEntry[INST_W-1:0] : INST_W'(NOP_INST);

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit
// Randomised bench for ifetch_unit. A memory responder answers fetches with a
// word derived from the address after a chosen latency. The reference model
// is the architectural fetch stream: after reset or a redirect, decode must
// see consecutive words starting at the (aligned) target, each paired with
// its address + 4. Expected pairs are queued whenever the stream is
// (re)started and a monitor compares every accepted head against the queue.
module tb_ifetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clk;
  logic              resetn;
  logic              iRedirect;
  logic [ADDR_W-1:0] iRedirectPC;
  logic              oImemReq;
  logic [ADDR_W-1:0] oImemAddr;
  logic              iImemAck;
  logic [INST_W-1:0] iImemData;
  logic              oValid;
  logic [INST_W-1:0] oInst;
  logic [ADDR_W-1:0] oPCPlus4;
  logic              iReady;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } expEntry_t;

  expEntry_t   expQ[$];
  logic [31:0] nextExpPc;
  int          checks = 0;
  int          failures = 0;
  int          popCount = 0;
  int          fixLat = 0;
  bit          forceAck = 0;
  bit          prevRedirect = 0;
  bit          found;

  ifetch_unit #(
    .ADDR_W   (ADDR_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC),
    .oImemReq    (oImemReq),
    .oImemAddr   (oImemAddr),
    .iImemAck    (iImemAck),
    .iImemData   (iImemData),
    .oValid      (oValid),
    .oInst       (oInst),
    .oPCPlus4    (oPCPlus4),
    .iReady      (iReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h00C0_FFEE;
  endfunction

  function automatic void modelFill();
    while (expQ.size() < 16) begin
      expQ.push_back('{nextExpPc + 32'd4, memFn(nextExpPc)});
      nextExpPc = nextExpPc + 32'd4;
    end
  endfunction

  function automatic void modelRestart(input logic [31:0] pc);
    expQ.delete();
    nextExpPc = {pc[31:2], 2'b00};
    modelFill();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    iRedirect   = 1'b1;
    iRedirectPC = pc;
    modelRestart(pc);
    @(posedge clk); #1;
    iRedirect   = 1'b0;
  endtask

  // Random decode backpressure, random memory latency and occasional
  // redirects, some close to the top of the address space to cover wrap.
  task automatic applyStimulus(input int n);
    logic [31:0] tgt;
    fixLat = -1;
    for (int i = 0; i < n; i++) begin
      iReady = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0) begin
        tgt = $urandom();
        if ($urandom_range(0, 1) == 1) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
        iRedirect   = 1'b1;
        iRedirectPC = tgt;
        modelRestart(tgt);
      end else begin
        iRedirect = 1'b0;
      end
      @(posedge clk); #1;
    end
    iRedirect = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rstReq", oImemReq, 0);
    checkOutput("rstAddr", oImemAddr, RESET_PC);
    checkOutput("rstValid", oValid, 0);
    checkOutput("rstInst", oInst, 0);
    checkOutput("rstPc4", oPCPlus4, 0);
  endtask

  // Memory responder: acks after the chosen latency, and checks that an
  // unanswered request keeps its address until it is acknowledged.
  initial begin : responder
    int          pendCnt;
    int          curLat;
    int          effLat;
    bit          prevReq;
    bit          prevAck;
    logic [31:0] prevAddr;
    pendCnt  = 0;
    curLat   = 0;
    prevReq  = 0;
    prevAck  = 0;
    prevAddr = '0;
    iImemAck  = 1'b0;
    iImemData = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pendCnt = 0;
        prevReq = 0;
        prevAck = 0;
      end else begin
        if (prevReq && !prevAck) begin
          checkOutput("reqHold", oImemReq, 1);
          checkOutput("addrHold", oImemAddr, prevAddr);
        end
        if (forceAck) begin
          iImemAck  = 1'b1;
          iImemData = 32'hDEAD_BEEF;
        end else if (oImemReq) begin
          if (!(prevReq && !prevAck)) begin
            pendCnt = 0;
            curLat  = $urandom_range(0, 3);
          end
          effLat = (fixLat >= 0) ? fixLat : curLat;
          if (pendCnt >= effLat) begin
            iImemAck  = 1'b1;
            iImemData = memFn(oImemAddr);
          end else begin
            pendCnt++;
          end
        end
        prevReq  = oImemReq;
        prevAck  = iImemAck;
        prevAddr = oImemAddr;
      end
      @(posedge clk); #1;
      iImemAck = 1'b0;
    end
  end

  // Monitor: every head accepted by decode must be the next word of the
  // architectural stream; an empty FIFO shows zeros; a redirect empties it.
  initial begin : monitor
    expEntry_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prevRedirect = 0;
      end else begin
        if (prevRedirect) checkOutput("flushValid", oValid, 0);
        if (!oValid) begin
          checkOutput("emptyInst", oInst, 0);
          checkOutput("emptyPc4", oPCPlus4, 0);
        end else if (iReady && !iRedirect) begin
          e = expQ.pop_front();
          modelFill();
          checkOutput("headPc4", oPCPlus4, e.pc4);
          checkOutput("headInst", oInst, e.inst);
          popCount++;
        end
        prevRedirect = iRedirect;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    resetn      = 1'b0;
    iRedirect   = 1'b0;
    iRedirectPC = '0;
    iReady      = 1'b0;
    fixLat      = 0;
    modelRestart(RESET_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetValues();

    // Back-to-back fetches with same-cycle acks.
    @(posedge clk); #1;
    resetn = 1'b1;
    iReady = 1'b1;
    @(negedge clk);
    checkOutput("idleReq", oImemReq, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("b2bReq", oImemReq, 1);
      checkOutput("b2bAddr", oImemAddr, 32'(4 * k));
      checkOutput("b2bValid", oValid, (k >= 1) ? 1 : 0);
    end
    @(posedge clk); #1;
    applyStimulus(60);

    // Fill the FIFO with decode stalled, then release one entry.
    fixLat = 0;
    iReady = 1'b0;
    redirect(32'h0);
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("fullReq", oImemReq, 0);
    checkOutput("fullValid", oValid, 1);
    checkOutput("fullHead", oPCPlus4, 32'h4);
    @(posedge clk); #1;
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    @(negedge clk);
    checkOutput("refillReq", oImemReq, 1);
    checkOutput("refillAddr", oImemAddr, 32'h10);

    // Redirect while the fetch of address 8 is outstanding.
    @(posedge clk); #1;
    fixLat = 3;
    iReady = 1'b1;
    redirect(32'h0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (oImemReq && oImemAddr == 32'h8) found = 1;
    end
    checkOutput("waitAddr8", found, 1);
    @(posedge clk); #1;
    redirect(32'h103);
    @(negedge clk);
    checkOutput("dropReq", oImemReq, 1);
    checkOutput("dropAddr", oImemAddr, 32'h8);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (oImemReq && oImemAddr == 32'h100) found = 1;
    end
    checkOutput("waitAddr100", found, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (oValid) found = 1;
      else @(negedge clk);
    end
    checkOutput("waitFirstValid", found, 1);
    checkOutput("firstPc4", oPCPlus4, 32'h104);

    // Redirect coinciding with an ack and a pop while two entries are held.
    @(posedge clk); #1;
    fixLat = 0;
    iReady = 1'b0;
    redirect(32'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    iRedirect   = 1'b1;
    iRedirectPC = 32'h300;
    iReady      = 1'b1;
    modelRestart(32'h300);
    @(negedge clk);
    checkOutput("rdAckReq", oImemReq, 1);
    checkOutput("rdAckAddr", oImemAddr, 32'h208);
    checkOutput("rdAckValid", oValid, 1);
    @(posedge clk); #1;
    iRedirect = 1'b0;
    @(negedge clk);
    checkOutput("rdAckFlush", oValid, 0);
    checkOutput("rdAckNewAddr", oImemAddr, 32'h300);

    // Steady push and pop with three entries held.
    @(posedge clk); #1;
    iReady = 1'b0;
    redirect(32'h400);
    repeat (3) begin @(posedge clk); #1; end
    iReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("steadyReq", oImemReq, 1);
      checkOutput("steadyValid", oValid, 1);
      @(posedge clk); #1;
    end
    iReady = 1'b0;
    @(negedge clk);
    checkOutput("lastPushReq", oImemReq, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("steadyThenFull", oImemReq, 0);

    // Reset in the middle of a dropped fetch, stray ack just after release.
    @(posedge clk); #1;
    fixLat = 5;
    redirect(32'h500);
    redirect(32'h600);
    @(negedge clk);
    checkOutput("preRstDropReq", oImemReq, 1);
    checkOutput("preRstDropAddr", oImemAddr, 32'h500);
    @(posedge clk); #1;
    resetn = 1'b0;
    modelRestart(RESET_PC);
    @(negedge clk);
    checkResetValues();
    @(posedge clk); #1;
    resetn   = 1'b1;
    forceAck = 1'b1;
    fixLat   = 0;
    iReady   = 1'b1;
    @(negedge clk);
    checkOutput("strayIdleReq", oImemReq, 0);
    checkOutput("strayIdleValid", oValid, 0);
    @(posedge clk); #1;
    forceAck = 1'b0;
    @(negedge clk);
    checkOutput("strayIgnored", oValid, 0);
    checkOutput("postRstReq", oImemReq, 1);
    checkOutput("postRstAddr", oImemAddr, RESET_PC);
    @(posedge clk); #1;

    applyStimulus(80);
    iReady = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("progress", (popCount >= 40) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
